inverse_substitution_box_generator: RTL and testbench



---
 rtl/mars_sbox_pkg.sv | 16 +
 rtl/inverse_sbox_ram.sv | 40 ++++
 rtl/inverse_substitution_box_generator.sv | 119 +++++++++++
 tb/tb_inverse_substitution_box_generator.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mars_sbox_pkg.sv
// rtl/mars_sbox_pkg.sv - shared S-box widths, byte type and inverse-generator states
package mars_sbox_pkg;

  localparam int SBOX_DATA_W  = 8;
  localparam int SBOX_ENTRIES = 256;

  typedef logic [SBOX_DATA_W-1:0] sbox_byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } inv_sbox_state_t;

endpackage

// File: rtl/inverse_sbox_ram.sv
// rtl/inverse_sbox_ram.sv - inverse table storage, one sync write port, one registered read port
module inverse_sbox_ram
  import mars_sbox_pkg::*;
#(
  parameter int DATA_W  = SBOX_DATA_W,
  parameter int ENTRIES = SBOX_ENTRIES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [DATA_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  // Table contents are never reset; only the read register is.
  logic [DATA_W-1:0] mem_q [ENTRIES];
  logic [DATA_W-1:0] rd_data_q;

  // Write port: plain synchronous write, no reset on the array.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read register: captures on a read request, otherwise holds its last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/inverse_substitution_box_generator.sv
// rtl/inverse_substitution_box_generator.sv - builds inv[sbox[i]]=i from a streamed forward box, checks bijection, serves lookups
module inverse_substitution_box_generator
  import mars_sbox_pkg::*;
#(
  parameter int DATA_W  = SBOX_DATA_W,
  parameter int ENTRIES = SBOX_ENTRIES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              enable_bar,
  input  logic              sbox_valid,
  input  logic [DATA_W-1:0] sbox_value,
  output logic              ready,
  output logic              error,
  output logic [DATA_W:0]   load_count,
  input  logic              lookup_valid,
  input  logic [DATA_W-1:0] lookup_byte,
  output logic              result_valid,
  output logic [DATA_W-1:0] result_byte
);

  localparam logic [DATA_W:0] LAST_INDEX = (DATA_W+1)'(ENTRIES - 1);

  inv_sbox_state_t   state_q;
  logic [DATA_W:0]   load_count_q;
  logic [DATA_W:0]   load_count_d;
  logic [ENTRIES-1:0] seen_q;
  logic              ready_q;
  logic              error_q;
  logic              result_valid_q;

  logic accept;
  logic duplicate;
  logic ram_wr_en;
  logic lookup_accept;

  // Qualify load and lookup requests; start wins over both in the same cycle.
  always_comb begin
    accept        = (state_q == LOAD) && sbox_valid && !enable_bar && !start && !reset;
    duplicate     = seen_q[sbox_value];
    ram_wr_en     = accept && !duplicate;
    lookup_accept = (state_q == DONE) && lookup_valid && !start && !reset;
    load_count_d  = load_count_q + 1'b1;
  end

  // Control FSM with registered status outputs; a full seen bitmap means the box is a bijection.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      load_count_q   <= '0;
      seen_q         <= '0;
      ready_q        <= 1'b0;
      error_q        <= 1'b0;
      result_valid_q <= 1'b0;
    end else if (start) begin
      state_q        <= LOAD;
      load_count_q   <= '0;
      seen_q         <= '0;
      ready_q        <= 1'b0;
      error_q        <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          result_valid_q <= 1'b0;
        end
        LOAD: begin
          result_valid_q <= 1'b0;
          if (accept) begin
            load_count_q <= load_count_d;
            if (duplicate) begin
              state_q <= ERROR;
              error_q <= 1'b1;
            end else begin
              seen_q[sbox_value] <= 1'b1;
              if (load_count_q == LAST_INDEX) begin
                state_q <= DONE;
                ready_q <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          result_valid_q <= lookup_valid;
        end
        ERROR: begin
          ready_q        <= 1'b0;
          error_q        <= 1'b1;
          result_valid_q <= 1'b0;
        end
        default: begin
          state_q        <= IDLE;
          result_valid_q <= 1'b0;
        end
      endcase
    end
  end

  inverse_sbox_ram #(
    .DATA_W  (DATA_W),
    .ENTRIES (ENTRIES)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (ram_wr_en),
    .wr_addr_i (sbox_value),
    .wr_data_i (load_count_q[DATA_W-1:0]),
    .rd_en_i   (lookup_accept),
    .rd_addr_i (lookup_byte),
    .rd_data_o (result_byte)
  );

  assign ready        = ready_q;
  assign error        = error_q;
  assign load_count   = load_count_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_inverse_substitution_box_generator.sv
// tb/tb_inverse_substitution_box_generator.sv - directed table-driven bench for the inverse S-box generator
module tb_inverse_substitution_box_generator;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       enable_bar;
  logic       sbox_valid;
  logic [7:0] sbox_value;
  logic       ready;
  logic       error;
  logic [8:0] load_count;
  logic       lookup_valid;
  logic [7:0] lookup_byte;
  logic       result_valid;
  logic [7:0] result_byte;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         kind;
    logic [7:0] lookup;
    logic [7:0] expected;
  } vec_t;

  vec_t vecs [14];

  inverse_substitution_box_generator dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .enable_bar   (enable_bar),
    .sbox_valid   (sbox_valid),
    .sbox_value   (sbox_value),
    .ready        (ready),
    .error        (error),
    .load_count   (load_count),
    .lookup_valid (lookup_valid),
    .lookup_byte  (lookup_byte),
    .result_valid (result_valid),
    .result_byte  (result_byte)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // kind 0 identity, 1 rotate by one, 2 xor 0xA5, 3 identity with index 7 duplicating 0x03
  function automatic logic [7:0] box(input int kind, input int i);
    logic [7:0] b;
    b = i[7:0];
    case (kind)
      1:       box = b + 8'd1;
      2:       box = b ^ 8'hA5;
      3:       box = (i == 7) ? 8'h03 : b;
      default: box = b;
    endcase
  endfunction

  // Pulse start, then feed n entries one per cycle; optional 10-cycle enable_bar stall at pause_at.
  task automatic load_box(input int kind, input int pause_at, input int n);
    @(negedge clk);
    start = 1'b1; sbox_valid = 1'b0; lookup_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("load_count_after_start", load_count, 0);
    for (int i = 0; i < n; i++) begin
      sbox_valid = 1'b1;
      sbox_value = box(kind, i);
      if (i == pause_at) begin
        enable_bar = 1'b1;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          chk("load_count_frozen", load_count, i);
        end
        enable_bar = 1'b0;
      end
      @(negedge clk);
      if (i == 254) chk("ready_not_early", ready, 0);
    end
    sbox_valid = 1'b0;
    if (n == 256) begin
      chk("ready_after_load", ready, 1);
      chk("load_count_full", load_count, 256);
      chk("error_clean_load", error, 0);
    end
  endtask

  // Back-to-back lookups of every vector of this kind, then check result_valid falls and data holds.
  task automatic run_vectors(input int kind);
    logic [7:0] last;
    logic       pending;
    last = 8'h00;
    pending = 1'b0;
    for (int v = 0; v < 14; v++) begin
      if (vecs[v].kind == kind) begin
        lookup_valid = 1'b1;
        lookup_byte  = vecs[v].lookup;
        @(negedge clk);
        chk("result_valid", result_valid, 1);
        chk("result_byte", result_byte, vecs[v].expected);
        last = vecs[v].expected;
        pending = 1'b1;
      end
    end
    lookup_valid = 1'b0;
    @(negedge clk);
    chk("result_valid_drop", result_valid, 0);
    if (pending) chk("result_byte_hold", result_byte, last);
  endtask

  initial begin
    vecs[0]  = '{0, 8'h5A, 8'h5A};
    vecs[1]  = '{0, 8'h00, 8'h00};
    vecs[2]  = '{0, 8'hFF, 8'hFF};
    vecs[3]  = '{0, 8'h81, 8'h81};
    vecs[4]  = '{1, 8'h00, 8'hFF};
    vecs[5]  = '{1, 8'h10, 8'h0F};
    vecs[6]  = '{1, 8'hFF, 8'hFE};
    vecs[7]  = '{1, 8'h80, 8'h7F};
    vecs[8]  = '{1, 8'h01, 8'h00};
    vecs[9]  = '{2, 8'h00, 8'hA5};
    vecs[10] = '{2, 8'hA5, 8'h00};
    vecs[11] = '{2, 8'hFF, 8'h5A};
    vecs[12] = '{2, 8'h3C, 8'h99};
    vecs[13] = '{2, 8'h5A, 8'hFF};

    reset = 1'b1; start = 1'b0; enable_bar = 1'b0; sbox_valid = 1'b0;
    sbox_value = 8'h00; lookup_valid = 1'b0; lookup_byte = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_ready", ready, 0);
    chk("reset_error", error, 0);
    chk("reset_load_count", load_count, 0);
    chk("reset_result_valid", result_valid, 0);
    chk("reset_result_byte", result_byte, 0);

    lookup_valid = 1'b1; lookup_byte = 8'h12; sbox_valid = 1'b1;
    @(negedge clk);
    chk("idle_lookup_ignored", result_valid, 0);
    chk("idle_load_ignored", load_count, 0);
    lookup_valid = 1'b0; sbox_valid = 1'b0;

    load_box(0, -1, 256);
    run_vectors(0);
    sbox_valid = 1'b1; sbox_value = 8'h44;
    @(negedge clk);
    chk("done_load_count_holds", load_count, 256);
    sbox_valid = 1'b0;

    load_box(1, -1, 256);
    run_vectors(1);

    load_box(3, -1, 8);
    chk("dup_error", error, 1);
    chk("dup_ready", ready, 0);
    sbox_valid = 1'b1; sbox_value = 8'h08;
    lookup_valid = 1'b1; lookup_byte = 8'h03;
    @(negedge clk);
    chk("dup_lookup_ignored", result_valid, 0);
    chk("dup_error_sticky", error, 1);
    sbox_valid = 1'b0; lookup_valid = 1'b0;

    load_box(0, -1, 256);
    run_vectors(0);

    load_box(1, 50, 256);
    run_vectors(1);

    load_box(1, -1, 100);
    chk("mid_load_count", load_count, 100);
    chk("mid_load_no_lookup", result_valid, 0);
    sbox_valid = 1'b1; sbox_value = 8'h64; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; sbox_valid = 1'b0;
    chk("midrst_ready", ready, 0);
    chk("midrst_error", error, 0);
    chk("midrst_load_count", load_count, 0);
    chk("midrst_result_valid", result_valid, 0);
    chk("midrst_result_byte", result_byte, 0);
    sbox_valid = 1'b1;
    @(negedge clk);
    chk("midrst_idle", load_count, 0);
    sbox_valid = 1'b0;
    load_box(1, -1, 256);
    run_vectors(1);

    start = 1'b1; lookup_valid = 1'b1; lookup_byte = 8'h00;
    @(negedge clk);
    start = 1'b0; lookup_valid = 1'b0;
    chk("restart_ready", ready, 0);
    chk("restart_no_result", result_valid, 0);
    load_box(2, -1, 256);
    run_vectors(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
